// File: rtl/win_ser_pkg.sv
// Shared types and helpers for the window serialiser.
// The state encoding and the index-width rule live here so that the
// controller and the top agree on the width of out_idx.
package win_ser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,  // no window held
    EMIT = 1'b1   // window held, beats pending
  } state_t;

  // Width of a beat index: clog2(n), but never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win_ser_ctrl.sv
// Handshake controller for the window serialiser: two-state FSM, beat
// index counter and the ready/valid logic on both sides. Reset is
// synchronous and active-high, and it also gates the handshake outputs
// so nothing is offered or accepted while it is held.
module win_ser_ctrl
  import win_ser_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [idx_w(N)-1:0]  out_idx,
  output logic                 out_last,
  output logic                 load
);

  localparam int            IW   = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx_nxt;
  logic          out_xfer;

  // Handshake outputs derived from the registered state.
  assign out_valid = !rst && (state == EMIT);
  assign out_last  = out_valid && (out_idx == LAST);
  assign in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
  assign load      = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next state and next beat index.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    idx_nxt   = out_idx;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nxt = EMIT;
          idx_nxt   = '0;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (out_idx == LAST) begin
            // A new window loaded on the final beat continues without a bubble.
            state_nxt = load ? EMIT : IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = out_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      out_idx <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/window_serialiser.sv
// Window serialiser: captures an N x N window and emits it as N beats of
// N lanes each. Default order is column c per beat (lane j = element
// j*N+c). Defining WIN_SER_ROW_MODE_EN switches to row r per beat
// (lane j = element r*N+j); timing and handshake are the same in both.
module window_serialiser
  import win_ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*N*DATA_W-1:0]      in_win,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*DATA_W-1:0]        out_vec,
  output logic [idx_w(N)-1:0]        out_idx,
  output logic                       out_last
);

  logic                  load;
  logic [N*N*DATA_W-1:0] hold;

  win_ser_ctrl #(.N(N)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .load      (load)
  );

  // Holding register: whole window captured on an input transfer.
  always_ff @(posedge clk) begin
    // NOTE: the holding register is cleared on reset so a discarded window
    // can never leak into a later beat.
    if (rst) begin
      hold <= '0;
    end else if (load) begin
      hold <= in_win;
    end
  end

  // Lane mux: select the N elements of the current beat, zero when idle.
  always_comb begin
    int k;
    out_vec = '0;
    k       = 0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
`ifdef WIN_SER_ROW_MODE_EN
        k = int'(out_idx) * N + j;
`else
        k = j * N + int'(out_idx);
`endif
        out_vec[j*DATA_W +: DATA_W] = hold[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_window_serialiser.sv
// Self-checking bench for window_serialiser (N=5 main instance, N=3 side
// instance). A transaction-level model expands each accepted window into
// its queue of expected beats and is compared with the N=5 DUT every cycle;
// directed literal checks pin specific beats of both instances.
module tb_window_serialiser;

  localparam int DW = 8;
  localparam int N5 = 5;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst;

  logic             in_valid, in_ready, out_valid, out_ready, out_last;
  logic [N5*N5*DW-1:0] in_win;
  logic [N5*DW-1:0] out_vec;
  logic [2:0]       out_idx;

  logic             in_valid3, in_ready3, out_valid3, out_ready3, out_last3;
  logic [N3*N3*DW-1:0] in_win3;
  logic [N3*DW-1:0] out_vec3;
  logic [1:0]       out_idx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_serialiser #(.DATA_W(DW), .N(N5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_win(in_win), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_idx(out_idx), .out_last(out_last)
  );

  window_serialiser #(.DATA_W(DW), .N(N3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_win(in_win3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_vec(out_vec3), .out_idx(out_idx3), .out_last(out_last3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] pack5(input int a, b, c, d, e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [23:0] pack3(input int a, b, c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  // Window with element k = base + k.
  function automatic logic [N5*N5*DW-1:0] make_win5(input int base);
    logic [N5*N5*DW-1:0] w;
    for (int k = 0; k < N5*N5; k++) w[k*DW +: DW] = 8'(base + k);
    return w;
  endfunction

  // ---------------- behavioural model (N=5) ----------------
  typedef struct {
    logic [N5*DW-1:0] vec;
    int               idx;
  } beat_t;

  beat_t q[$];

  always @(posedge clk) begin
    bit rdy;
    beat_t b;
    if (rst) begin
      q.delete();
    end else begin
      rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        for (int c = 0; c < N5; c++) begin
          b.idx = c;
          for (int j = 0; j < N5; j++) begin
`ifdef WIN_SER_ROW_MODE_EN
            b.vec[j*DW +: DW] = in_win[(c*N5 + j)*DW +: DW];
`else
            b.vec[j*DW +: DW] = in_win[(j*N5 + c)*DW +: DW];
`endif
          end
          q.push_back(b);
        end
      end
    end
  end

  // Per-cycle comparison of the N=5 DUT against the model.
  always @(negedge clk) begin
    bit mv;
    mv = q.size() > 0;
    check("in_ready", in_ready, !rst && (q.size() == 0 || (q.size() == 1 && out_ready)));
    check("out_valid", out_valid, mv);
    check("out_vec", out_vec, mv ? q[0].vec : '0);
    check("out_last", out_last, mv && q[0].idx == N5 - 1);
    if (mv) check("out_idx", out_idx, q[0].idx);
  end

  // Expected literal beat c for window base b (column or row order).
  function automatic logic [39:0] lit5(input int b, input int c);
`ifdef WIN_SER_ROW_MODE_EN
    return pack5(b + c*5, b + c*5 + 1, b + c*5 + 2, b + c*5 + 3, b + c*5 + 4);
`else
    return pack5(b + c, b + c + 5, b + c + 10, b + c + 15, b + c + 20);
`endif
  endfunction

  task automatic load_a();
    @(posedge clk); #1;
    in_win   = make_win5(1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [39:0] pin;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_win = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    for (int k = 0; k < N3*N3; k++) in_win3[k*DW +: DW] = 8'(k + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_vec", out_vec, '0);
    #1 rst = 1'b0;

    // Single window, out_ready held high.
    load_a();
`ifdef WIN_SER_ROW_MODE_EN
    pin = pack5(1, 2, 3, 4, 5);
`else
    pin = pack5(1, 6, 11, 16, 21);
`endif
    for (int c = 0; c < N5; c++) begin
      @(negedge clk);
      check("single_idx", out_idx, c);
      check("single_last", out_last, c == N5 - 1);
      check("single_vec", out_vec, lit5(1, c));
      if (c == 0) check("single_beat0_pin", out_vec, pin);
`ifdef WIN_SER_ROW_MODE_EN
      if (c == 4) check("single_beat4_pin", out_vec, pack5(21, 22, 23, 24, 25));
`else
      if (c == 4) check("single_beat4_pin", out_vec, pack5(5, 10, 15, 20, 25));
`endif
    end
    @(negedge clk);
    check("single_idle", out_valid, 1'b0);

    // Stall three cycles at beat 2.
    load_a();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_vec", out_vec, lit5(1, 2));
      check("stall_idx", out_idx, 2);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_idle", out_valid, 1'b0);

    // Two windows back to back.
    @(posedge clk); #1;
    in_win = make_win5(1); in_valid = 1'b1;
    @(posedge clk); #1;
    in_win = make_win5(101);
    for (int i = 0; i < 2*N5; i++) begin
      if (i == N5) begin
        @(posedge clk); #1 in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_idx", out_idx, i % N5);
`ifdef WIN_SER_ROW_MODE_EN
      if (i == N5) check("b2b_beat5_pin", out_vec, pack5(101, 102, 103, 104, 105));
`else
      if (i == N5) check("b2b_beat5_pin", out_vec, pack5(101, 106, 111, 116, 121));
`endif
    end
    @(negedge clk);
    check("b2b_idle", out_valid, 1'b0);

    // Reset pulsed while beat 3 is on the output.
    load_a();
    repeat (4) @(negedge clk);
    check("rst_pre_idx", out_idx, 3);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_vec", out_vec, '0);
    check("rst_idx", out_idx, 0);
    check("rst_in_ready", in_ready, 1'b0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_beats", out_valid, 1'b0);
    load_a();
    @(negedge clk);
    check("rst_next_idx", out_idx, 0);
    check("rst_next_vec", out_vec, pin);
    repeat (6) @(posedge clk);

    // N = 3 instance.
    @(posedge clk); #1 in_valid3 = 1'b1;
    @(posedge clk); #1 in_valid3 = 1'b0;
    for (int c = 0; c < N3; c++) begin
      @(negedge clk);
      check("n3_valid", out_valid3, 1'b1);
      check("n3_idx", out_idx3, c);
      check("n3_last", out_last3, c == N3 - 1);
`ifdef WIN_SER_ROW_MODE_EN
      check("n3_vec", out_vec3, pack3(c*3 + 1, c*3 + 2, c*3 + 3));
`else
      check("n3_vec", out_vec3, pack3(c + 1, c + 4, c + 7));
`endif
    end
    @(negedge clk);
    check("n3_idle_valid", out_valid3, 1'b0);
    check("n3_idle_ready", in_ready3, 1'b1);
    check("n3_idle_vec", out_vec3, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
